// File: rtl/fb_port_arbiter.sv
// Framebuffer port arbiter: display reads take every RAM slot they need, repeated read
// addresses are served from a hold register, and the freed slots drain camera writes.
module fb_port_arbiter #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int RAM_LAT    = 1
) (
  input  logic                        vga_clk,
  input  logic                        rst_n,
  input  logic                        rd_en_i,
  input  logic [ADDR_W-1:0]           rd_addr_i,
  output logic [DATA_W-1:0]           rd_data_o,
  output logic                        rd_valid_o,
  input  logic                        wr_strobe_i,
  input  logic [ADDR_W-1:0]           wr_addr_i,
  input  logic [DATA_W-1:0]           wr_data_i,
  output logic                        ram_en_o,
  output logic                        ram_we_o,
  output logic [ADDR_W-1:0]           ram_addr_o,
  output logic [DATA_W-1:0]           ram_wdata_o,
  input  logic [DATA_W-1:0]           ram_rdata_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o,
  output logic [15:0]                 drop_cnt_o,
  input  logic                        ovf_clr_i
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [15:0]       drop_q, drop_d;
  logic              last_valid_q;
  logic [ADDR_W-1:0] last_addr_q;
  logic [RAM_LAT:0]  tag_vld_q, tag_hit_q;
  logic [DATA_W-1:0] hold_q, rd_data_q;
  logic              rd_valid_q, ram_en_q, ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic              rd_hit, rd_miss, fifo_full, fifo_empty, push, pop, drop;

  always_comb begin
    rd_hit     = rd_en_i && last_valid_q && (rd_addr_i == last_addr_q);
    rd_miss    = rd_en_i && !rd_hit;
    fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    fifo_empty = (level_q == '0);
    // Full check uses the pre-cycle level, so a same-cycle pop never rescues a push.
    push       = wr_strobe_i && !fifo_full;
    pop        = !rd_miss && !fifo_empty;
    drop       = wr_strobe_i && fifo_full;
    level_d    = level_q + LVL_W'(push) - LVL_W'(pop);
    drop_d     = drop_q;
    if (ovf_clr_i)
      drop_d = '0;
    else if (drop && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge vga_clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= wr_addr_i;
      fifo_data_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      drop_q       <= '0;
      last_valid_q <= 1'b0;
      last_addr_q  <= '0;
      tag_vld_q    <= '0;
      tag_hit_q    <= '0;
      hold_q       <= '0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
    end else begin
      level_q      <= level_d;
      drop_q       <= drop_d;
      last_valid_q <= rd_en_i;
      if (rd_en_i)
        last_addr_q <= rd_addr_i;
      if (push)
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);

      ram_en_q <= rd_miss || pop;
      ram_we_q <= !rd_miss && pop;
      if (rd_miss) begin
        ram_addr_q <= rd_addr_i;
      end else if (pop) begin
        ram_addr_q  <= fifo_addr_q[rd_ptr_q];
        ram_wdata_q <= fifo_data_q[rd_ptr_q];
      end

      // Tag pipeline lines each request up with the cycle its RAM data returns.
      tag_vld_q[0] <= rd_en_i;
      tag_hit_q[0] <= rd_hit;
      for (int i = 1; i <= RAM_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_hit_q[i] <= tag_hit_q[i-1];
      end

      rd_valid_q <= tag_vld_q[RAM_LAT];
      if (tag_vld_q[RAM_LAT]) begin
        if (tag_hit_q[RAM_LAT]) begin
          rd_data_q <= hold_q;
        end else begin
          rd_data_q <= ram_rdata_i;
          hold_q    <= ram_rdata_i;
        end
      end
    end
  end

  assign rd_data_o    = rd_data_q;
  assign rd_valid_o   = rd_valid_q;
  assign ram_en_o     = ram_en_q;
  assign ram_we_o     = ram_we_q;
  assign ram_addr_o   = ram_addr_q;
  assign ram_wdata_o  = ram_wdata_q;
  assign fifo_level_o = level_q;
  assign drop_cnt_o   = drop_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: queue-based reference model, bench-side RAM, directed
// scenarios pinned with literal values, then a long randomized run.
module tb_fb_port_arbiter;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

  logic              vga_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rd_en = 1'b0;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              wr_strobe = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [4:0]        fifo_level;
  logic [15:0]       drop_cnt;
  logic              ovf_clr = 1'b0;

  always #5 vga_clk = ~vga_clk;

  fb_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(DEPTH), .RAM_LAT(1)) dut (
    .vga_clk(vga_clk), .rst_n(rst_n),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr), .rd_data_o(rd_data), .rd_valid_o(rd_valid),
    .wr_strobe_i(wr_strobe), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .fifo_level_o(fifo_level), .drop_cnt_o(drop_cnt),
    .ovf_clr_i(ovf_clr)
  );

  function automatic logic [15:0] init_val(input int a);
    return 16'(a) ^ 16'hA5A5;
  endfunction

  // Bench-side single-port RAM, one cycle read latency.
  logic [15:0] ram_mem [int];
  always @(posedge vga_clk) begin
    if (ram_en) begin
      if (ram_we)
        ram_mem[int'(ram_addr)] = ram_wdata;
      else
        ram_rdata <= ram_mem.exists(int'(ram_addr)) ? ram_mem[int'(ram_addr)] : init_val(int'(ram_addr));
    end
  end

  // Reference model: image of the framebuffer, write queue, scheduled read results.
  typedef struct { int a; logic [15:0] d; } wr_t;
  typedef struct { int due; logic [15:0] d; } rd_t;
  typedef struct { int cyc; bit we; int a; } op_t;

  logic [15:0] m_mem [int];
  wr_t  m_fifo [$];
  rd_t  m_rdq  [$];
  bit   m_pend;
  wr_t  m_pend_w;
  bit   m_lv;
  int   m_la;
  logic [15:0] m_hold;
  bit   m_ram_en, m_ram_we;
  int   m_ram_addr;
  logic [15:0] m_ram_wdata;
  int   m_drop;

  int   pc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  op_t  ramlog [$];
  rd_t  rdvlog [$];

  function automatic logic [15:0] m_read(input int a);
    return m_mem.exists(a) ? m_mem[a] : init_val(a);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_rdq.delete();
    m_pend = 0; m_lv = 0; m_la = 0; m_hold = '0;
    m_ram_en = 0; m_ram_we = 0; m_ram_addr = 0; m_ram_wdata = '0;
    m_drop = 0;
  endtask

  task automatic model_step(input bit re, input int ra, input bit ws, input int wa,
                            input logic [15:0] wd, input bit clr);
    bit hit, miss, full_pre;
    wr_t w;
    if (m_pend) begin
      m_mem[m_pend_w.a] = m_pend_w.d;
      m_pend = 0;
    end
    hit  = re && m_lv && (ra == m_la);
    miss = re && !hit;
    if (re) begin
      if (miss) m_hold = m_read(ra);
      m_rdq.push_back('{due: pc + 3, d: m_hold});
    end
    full_pre = (m_fifo.size() == DEPTH);
    m_ram_en = 0;
    m_ram_we = 0;
    if (miss) begin
      m_ram_en = 1;
      m_ram_addr = ra;
    end else if (m_fifo.size() > 0) begin
      w = m_fifo.pop_front();
      m_ram_en = 1; m_ram_we = 1;
      m_ram_addr = w.a; m_ram_wdata = w.d;
      m_pend = 1; m_pend_w = w;
    end
    if (ws && !full_pre) m_fifo.push_back('{a: wa, d: wd});
    if (clr) m_drop = 0;
    else if (ws && full_pre && m_drop < 65535) m_drop++;
    m_lv = re;
    if (re) m_la = ra;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, pc);
  endtask

  task automatic compare();
    bit ev;
    rd_t r;
    ev = (m_rdq.size() > 0) && (m_rdq[0].due == pc);
    check("rd_valid", 32'(rd_valid), 32'(ev));
    if (ev) begin
      r = m_rdq.pop_front();
      check("rd_data", 32'(rd_data), 32'(r.d));
    end
    check("ram_en", 32'(ram_en), 32'(m_ram_en));
    check("ram_we", 32'(ram_we), 32'(m_ram_we));
    check("ram_addr", 32'(ram_addr), 32'(m_ram_addr));
    if (m_ram_en && m_ram_we) check("ram_wdata", 32'(ram_wdata), 32'(m_ram_wdata));
    check("fifo_level", 32'(fifo_level), 32'(m_fifo.size()));
    check("drop_cnt", 32'(drop_cnt), 32'(m_drop));
    if (rd_valid) rdvlog.push_back('{due: pc, d: rd_data});
    if (ram_en) ramlog.push_back('{cyc: pc, we: ram_we, a: int'(ram_addr)});
  endtask

  // Called at a negedge; returns at the following negedge with outputs checked.
  task automatic step(input bit re, input int ra, input bit ws, input int wa,
                      input logic [15:0] wd, input bit clr);
    rd_en = re; rd_addr = ADDR_W'(ra);
    wr_strobe = ws; wr_addr = ADDR_W'(wa); wr_data = wd;
    ovf_clr = clr;
    model_step(re, ra, ws, wa, wd, clr);
    @(posedge vga_clk);
    pc++;
    @(negedge vga_clk);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_data"}, 32'(rd_data), 32'd0);
    check({tag, "_ram_en"}, 32'(ram_en), 32'd0);
    check({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    check({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    check({tag, "_ram_wdata"}, 32'(ram_wdata), 32'd0);
    check({tag, "_level"}, 32'(fifo_level), 32'd0);
    check({tag, "_drop"}, 32'(drop_cnt), 32'd0);
  endtask

  // Asynchronous reset asserted mid-cycle, released at the next negedge.
  task automatic mid_reset(input string tag);
    #2 rst_n = 1'b0;
    rd_en = 0; wr_strobe = 0; ovf_clr = 0;
    #1 check_zero_outputs(tag);
    model_reset();
    @(negedge vga_clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, nw, re, ra, ws;
    bit ok;
    model_reset();
    repeat (3) @(negedge vga_clk);
    check_zero_outputs("por");
    rst_n = 1'b1;

    // Reads in flight with queued writes, then reset.
    step(1, 1, 1, 50, 16'hAAAA, 0);
    step(1, 2, 1, 51, 16'hBBBB, 0);
    step(1, 3, 1, 52, 16'hCCCC, 0);
    step(1, 4, 0, 0, '0, 0);
    mid_reset("rst");
    rdvlog.delete();
    idle(6);
    check("rst_no_rd_valid_after", 32'(rdvlog.size()), 32'd0);

    // Reads 5,5,6,6 with empty FIFO.
    ramlog.delete(); rdvlog.delete();
    s = pc;
    step(1, 5, 0, 0, '0, 0);
    step(1, 5, 0, 0, '0, 0);
    step(1, 6, 0, 0, '0, 0);
    step(1, 6, 0, 0, '0, 0);
    idle(3);
    check("t2_ram_reads", 32'(ramlog.size()), 32'd2);
    if (ramlog.size() == 2) begin
      check("t2_read0_cyc", 32'(ramlog[0].cyc - s), 32'd1);
      check("t2_read0_addr", 32'(ramlog[0].a), 32'd5);
      check("t2_read1_cyc", 32'(ramlog[1].cyc - s), 32'd3);
      check("t2_read1_addr", 32'(ramlog[1].a), 32'd6);
    end
    check("t2_rdv_count", 32'(rdvlog.size()), 32'd4);
    if (rdvlog.size() == 4) begin
      check("t2_rdv0_cyc", 32'(rdvlog[0].due - s), 32'd3);
      check("t2_rdv3_cyc", 32'(rdvlog[3].due - s), 32'd6);
      check("t2_d0", 32'(rdvlog[0].d), 32'h0000A5A0);
      check("t2_d1", 32'(rdvlog[1].d), 32'h0000A5A0);
      check("t2_d2", 32'(rdvlog[2].d), 32'h0000A5A3);
      check("t2_d3", 32'(rdvlog[3].d), 32'h0000A5A3);
    end

    // Two queued writes drain only in hit slots.
    step(1, 20, 1, 100, 16'h1111, 0);
    step(1, 21, 1, 101, 16'h2222, 0);
    check("t3_level_prefill", 32'(fifo_level), 32'd2);
    ramlog.delete(); rdvlog.delete();
    s = pc;
    step(1, 10, 0, 0, '0, 0);
    step(1, 10, 0, 0, '0, 0);
    step(1, 11, 0, 0, '0, 0);
    step(1, 11, 0, 0, '0, 0);
    idle(3);
    check("t3_ram_ops", 32'(ramlog.size()), 32'd4);
    if (ramlog.size() == 4) begin
      check("t3_op1_cyc", 32'(ramlog[1].cyc - s), 32'd2);
      check("t3_op1_we", 32'(ramlog[1].we), 32'd1);
      check("t3_op1_addr", 32'(ramlog[1].a), 32'd100);
      check("t3_op3_cyc", 32'(ramlog[3].cyc - s), 32'd4);
      check("t3_op3_addr", 32'(ramlog[3].a), 32'd101);
    end
    if (rdvlog.size() == 6) begin
      check("t3_d10", 32'(rdvlog[3].d), 32'h0000A5AF);
      check("t3_d11", 32'(rdvlog[5].d), 32'h0000A5AE);
    end else check("t3_rdv_count", 32'(rdvlog.size()), 32'd6);

    // No reads: 20 back-to-back camera writes all retire in order.
    ramlog.delete();
    for (int i = 0; i < 20; i++) step(0, 0, 1, 300 + i, 16'(i * 7 + 3), 0);
    idle(3);
    check("t4_writes", 32'(ramlog.size()), 32'd20);
    ok = (ramlog.size() == 20);
    for (int i = 0; i < ramlog.size() && i < 20; i++)
      if (!ramlog[i].we || ramlog[i].a != 300 + i) ok = 0;
    check("t4_order", 32'(ok), 32'd1);
    check("t4_drop", 32'(drop_cnt), 32'd0);
    check("t4_level", 32'(fifo_level), 32'd0);

    // Unique reads every cycle: FIFO fills, 4 pixels dropped.
    for (int i = 0; i < 20; i++) step(1, 1000 + i, 1, 400 + i, 16'(16'h5000 + i), 0);
    check("t5_level_full", 32'(fifo_level), 32'd16);
    check("t5_drop4", 32'(drop_cnt), 32'd4);
    step(1, 1020, 0, 0, '0, 1);
    check("t5_drop_clr", 32'(drop_cnt), 32'd0);
    ramlog.delete();
    idle(20);
    nw = 0;
    foreach (ramlog[i]) if (ramlog[i].we) nw++;
    check("t5_drained", 32'(nw), 32'd16);
    check("t5_level_empty", 32'(fifo_level), 32'd0);

    // Hit to 7 while a write to 7 uses that slot: hit returns old data.
    ramlog.delete(); rdvlog.delete();
    s = pc;
    step(1, 7, 1, 7, 16'h1234, 0);
    step(1, 7, 0, 0, '0, 0);
    step(1, 8, 0, 0, '0, 0);
    step(1, 7, 0, 0, '0, 0);
    idle(4);
    if (ramlog.size() >= 2) begin
      check("t6_write_cyc", 32'(ramlog[1].cyc - s), 32'd2);
      check("t6_write_we", 32'(ramlog[1].we), 32'd1);
    end else check("t6_ram_ops", 32'(ramlog.size()), 32'd4);
    if (rdvlog.size() == 4) begin
      check("t6_miss_old", 32'(rdvlog[0].d), 32'h0000A5A2);
      check("t6_hit_old", 32'(rdvlog[1].d), 32'h0000A5A2);
      check("t6_reread_new", 32'(rdvlog[3].d), 32'h00001234);
    end else check("t6_rdv_count", 32'(rdvlog.size()), 32'd4);
    check("t6_ram_holds_new", 32'(ram_mem.exists(7) ? ram_mem[7] : 16'h0), 32'h00001234);

    // Randomized traffic, upscaler-like repeats, with one reset in the middle.
    ra = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) begin
        mid_reset("rnd_rst");
      end
      re = ($urandom_range(3) != 0) ? 1 : 0;
      if ($urandom_range(1) == 0) ra = $urandom_range(63);
      ws = $urandom_range(1);
      step(re[0], ra, ws[0], $urandom_range(63), 16'($urandom), ($urandom_range(63) == 0));
    end
    idle(25);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
